// File: rtl/usb_stream_arbiter.sv
// usb_stream_arbiter: packet-aware round-robin arbiter sharing one AXI-Stream sink between NUM_SOURCES producers.
// Define ARB_HEADER_EN to prefix every packet with a header beat 8'hA0 | grant_id.
module usb_stream_arbiter #(
   parameter int NUM_SOURCES = 2,
   parameter int DATA_WIDTH  = 8,
   parameter int MAX_BEATS   = 256
) (
   input  logic                                               clk,
   input  logic                                               rst,
   input  logic [NUM_SOURCES*DATA_WIDTH-1:0]                  s_tdata,
   input  logic [NUM_SOURCES-1:0]                             s_tvalid,
   input  logic [NUM_SOURCES-1:0]                             s_tlast,
   output logic [NUM_SOURCES-1:0]                             s_tready,
   output logic [DATA_WIDTH-1:0]                              m_tdata,
   output logic                                               m_tvalid,
   output logic                                               m_tlast,
   input  logic                                               m_tready,
   output logic [(NUM_SOURCES > 1 ? $clog2(NUM_SOURCES) : 1)-1:0] grant_id,
   output logic                                               busy,
   output logic [NUM_SOURCES-1:0]                             trunc_flags
);
   localparam int GW = NUM_SOURCES > 1 ? $clog2(NUM_SOURCES) : 1;
   localparam int CW = $clog2(MAX_BEATS);
`ifdef ARB_HEADER_EN
   typedef enum logic [1:0] {IDLE, HEADER, STREAM} state_t;
   localparam state_t FIRST = HEADER;
`else
   typedef enum logic [0:0] {IDLE, STREAM} state_t;
   localparam state_t FIRST = STREAM;
`endif
   state_t state, state_nx;
   logic [GW-1:0] last_grant, pick, cand;
   logic [CW-1:0] cnt;
   logic at_max, xfer;
   assign at_max = cnt == CW'(MAX_BEATS - 1);
   assign xfer = state == STREAM && m_tvalid && m_tready;
   // Walk downward so the nearest requester after last_grant is written last and wins.
   always_comb begin
      pick = last_grant;
      cand = '0;
      for (int i = NUM_SOURCES; i >= 1; i--) begin
         cand = GW'((int'(last_grant) + i) % NUM_SOURCES);
         if (s_tvalid[cand]) pick = cand;
      end
   end
   always_comb begin
      state_nx = state;
      m_tdata  = '0;
      m_tvalid = 1'b0;
      m_tlast  = 1'b0;
      s_tready = '0;
      case (state)
         IDLE: state_nx = |s_tvalid ? FIRST : IDLE;
`ifdef ARB_HEADER_EN
         HEADER: begin
            m_tvalid = 1'b1;
            m_tdata  = DATA_WIDTH'({4'hA, 4'(grant_id)});
            state_nx = m_tready ? STREAM : HEADER;
         end
`endif
         STREAM: begin
            m_tdata            = s_tdata[grant_id*DATA_WIDTH +: DATA_WIDTH];
            m_tvalid           = s_tvalid[grant_id];
            m_tlast            = s_tlast[grant_id] | at_max;
            s_tready[grant_id] = m_tready;
            state_nx           = m_tvalid && m_tready && m_tlast ? IDLE : STREAM;
         end
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         grant_id    <= '0;
         busy        <= 1'b0;
         last_grant  <= GW'(NUM_SOURCES - 1);
         cnt         <= '0;
         trunc_flags <= '0;
      end else begin
         if (state == IDLE && |s_tvalid) begin
            grant_id <= pick;
            busy     <= 1'b1;
         end
         if (xfer) begin
            cnt <= m_tlast ? '0 : cnt + 1'b1;
            if (m_tlast) begin
               busy       <= 1'b0;
               last_grant <= grant_id;
            end
            if (at_max && !s_tlast[grant_id]) trunc_flags[grant_id] <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_usb_stream_arbiter.sv
// tb_usb_stream_arbiter: vector table, directed sequences and randomized traffic for usb_stream_arbiter,
// compared against a cycle-level behavioural model of the arbitration rules.
module tb_usb_stream_arbiter;
   localparam int N = 2, W = 8, MB = 4;
`ifdef ARB_HEADER_EN
   localparam bit HDR = 1'b1;
`else
   localparam bit HDR = 1'b0;
`endif
   typedef struct { logic [W-1:0] d; logic l; } beat_t;
   typedef struct {
      logic [N-1:0] v; logic [N*W-1:0] d; logic [N-1:0] l;
      logic e_mv; logic [W-1:0] e_md; logic e_ml; logic e_busy;
   } vec_t;

   logic clk = 1'b0, rst = 1'b1;
   logic [N*W-1:0] s_tdata = '0;
   logic [N-1:0] s_tvalid = '0, s_tlast = '0, s_tready;
   logic [W-1:0] m_tdata;
   logic m_tvalid, m_tlast, m_tready = 1'b1, busy;
   logic [0:0] grant_id;
   logic [N-1:0] trunc_flags;
   int checks = 0, failures = 0;

   always #5 clk = ~clk;

   usb_stream_arbiter #(.NUM_SOURCES(N), .DATA_WIDTH(W), .MAX_BEATS(MB)) dut (
      .clk(clk), .rst(rst), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
      .s_tready(s_tready), .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
      .m_tready(m_tready), .grant_id(grant_id), .busy(busy), .trunc_flags(trunc_flags)
   );

   // model: owner=-1 means no grant; cnt counts source beats of the current grant
   int owner, last_g, cnt, gid;
   bit hdr;
   logic [N-1:0] tfl, e_rdy;
   logic e_mv, e_ml, e_busy;
   logic [W-1:0] e_md;
   beat_t q[N][$];
   int pkt_log[$];
   logic [W-1:0] src_log[$];
   logic [W:0] all_log[$];

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      owner = -1; last_g = N - 1; cnt = 0; gid = 0; hdr = 1'b0; tfl = '0;
      for (int i = 0; i < N; i++) q[i].delete();
      pkt_log.delete(); src_log.delete(); all_log.delete();
   endfunction

   function automatic void predict();
      e_mv = 1'b0; e_ml = 1'b0; e_md = '0; e_rdy = '0; e_busy = owner >= 0;
      if (owner >= 0 && hdr) begin
         e_mv = 1'b1;
         e_md = W'(8'hA0 | owner);
      end else if (owner >= 0) begin
         e_mv = s_tvalid[owner];
         e_md = s_tdata[owner*W +: W];
         e_ml = s_tlast[owner] || cnt == MB - 1;
         e_rdy[owner] = m_tready;
      end
   endfunction

   function automatic void advance();
      if (owner < 0) begin
         for (int k = 1; k <= N; k++)
            if (s_tvalid[(last_g + k) % N]) begin
               owner = (last_g + k) % N;
               break;
            end
         if (owner >= 0) begin
            gid = owner; hdr = HDR; cnt = 0;
         end
      end else if (hdr) begin
         hdr = !m_tready;
      end else if (e_mv && m_tready) begin
         if (!e_ml) cnt++;
         else begin
            if (cnt == MB - 1 && !s_tlast[owner]) tfl[owner] = 1'b1;
            last_g = owner; owner = -1; cnt = 0;
         end
      end
   endfunction

   task automatic cycle();
      #1;
      predict();
      chk("m_tvalid", m_tvalid, e_mv);
      chk("m_tdata", m_tdata, e_md);
      chk("m_tlast", m_tlast, e_ml);
      chk("s_tready", s_tready, e_rdy);
      chk("busy", busy, e_busy);
      chk("grant_id", grant_id, gid);
      chk("trunc_flags", trunc_flags, tfl);
      if (m_tvalid && m_tready) begin
         all_log.push_back({m_tlast, m_tdata});
         if (|s_tready) src_log.push_back(m_tdata);
         if (m_tlast) pkt_log.push_back(int'(grant_id));
      end
      @(posedge clk);
      advance();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1; s_tvalid = '0; s_tdata = '0; s_tlast = '0; m_tready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   task automatic step(int rmode, bit gaps);
      for (int i = 0; i < N; i++) begin
         if (q[i].size() > 0 && (!gaps || $urandom_range(3) != 0)) begin
            s_tvalid[i] = 1'b1; s_tdata[i*W +: W] = q[i][0].d; s_tlast[i] = q[i][0].l;
         end else begin
            s_tvalid[i] = 1'b0; s_tdata[i*W +: W] = W'($urandom); s_tlast[i] = 1'b0;
         end
      end
      m_tready = rmode == 0 ? 1'b1 : rmode == 1 ? ~m_tready : 1'($urandom);
      cycle();
      for (int i = 0; i < N; i++)
         if (s_tvalid[i] && e_rdy[i]) q[i].delete(0);
   endtask

   function automatic int pending();
      int s = 0;
      for (int i = 0; i < N; i++) s += q[i].size();
      return s;
   endfunction

   task automatic run(int n, int rmode, bit gaps);
      repeat (n) step(rmode, gaps);
   endtask

   task automatic drain(int max, int rmode, bit gaps);
      int n = 0;
      while (pending() > 0 && n < max) begin
         step(rmode, gaps);
         n++;
      end
      chk("drain", pending(), 0);
   endtask

   task automatic add_pkt(int src, int base, int len);
      for (int j = 0; j < len; j++) q[src].push_back('{W'(base + j), j == len - 1});
   endtask

   initial begin
      vec_t tbl[6];
      logic [W-1:0] alt_exp[12];
      tbl[0] = '{2'b01, 16'h0010, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0};
      tbl[1] = '{2'b01, 16'h0010, 2'b00, 1'b1, 8'h10, 1'b0, 1'b1};
      tbl[2] = '{2'b01, 16'h0011, 2'b00, 1'b1, 8'h11, 1'b0, 1'b1};
      tbl[3] = '{2'b01, 16'h0012, 2'b00, 1'b1, 8'h12, 1'b0, 1'b1};
      tbl[4] = '{2'b01, 16'h0013, 2'b01, 1'b1, 8'h13, 1'b1, 1'b1};
      tbl[5] = '{2'b00, 16'h0000, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0};
      alt_exp = '{8'h20, 8'h21, 8'h22, 8'h40, 8'h41, 8'h42, 8'h23, 8'h24, 8'h25, 8'h43, 8'h44, 8'h45};

      do_reset();
      #1;
      chk("rst_m_tvalid", m_tvalid, 0);
      chk("rst_m_tlast", m_tlast, 0);
      chk("rst_m_tdata", m_tdata, 0);
      chk("rst_s_tready", s_tready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_grant_id", grant_id, 0);
      chk("rst_trunc_flags", trunc_flags, 0);

`ifndef ARB_HEADER_EN
      m_tready = 1'b1;
      foreach (tbl[i]) begin
         s_tvalid = tbl[i].v; s_tdata = tbl[i].d; s_tlast = tbl[i].l;
         #1;
         chk("tbl_m_tvalid", m_tvalid, tbl[i].e_mv);
         chk("tbl_m_tdata", m_tdata, tbl[i].e_md);
         chk("tbl_m_tlast", m_tlast, tbl[i].e_ml);
         chk("tbl_busy", busy, tbl[i].e_busy);
         cycle();
      end
`endif

      // two continuously requesting sources alternate by whole packets
      do_reset();
      add_pkt(0, 'h20, 3); add_pkt(1, 'h40, 3); add_pkt(0, 'h23, 3); add_pkt(1, 'h43, 3);
      drain(100, 0, 1'b0);
      run(2, 0, 1'b0);
      chk("alt_count", pkt_log.size(), 4);
      for (int i = 0; i < 4; i++) chk("alt_order", pkt_log.size() > i ? pkt_log[i] : -1, i % 2);
      for (int i = 0; i < 12; i++)
         chk("alt_data", src_log.size() > i ? 32'(src_log[i]) : 32'hDEAD, 32'(alt_exp[i]));

      // toggling backpressure over a 5-beat packet
      src_log.delete();
      add_pkt(0, 'h30, 5);
      drain(100, 1, 1'b0);
      run(2, 1, 1'b0);
      chk("bp_count", src_log.size(), 5);
      for (int i = 0; i < 5; i++)
         chk("bp_data", src_log.size() > i ? 32'(src_log[i]) : 32'hDEAD, 32'h30 + i);

      // truncation at MAX_BEATS, remainder re-arbitrated after source 0
      do_reset();
      add_pkt(1, 'h61, 6);
      run(2, 0, 1'b0);
      add_pkt(0, 'h01, 2);
      drain(100, 0, 1'b0);
      run(3, 0, 1'b0);
      chk("trunc_final", trunc_flags, 2'b10);
      chk("trunc_pkts", pkt_log.size(), 3);
      for (int i = 0; i < 3; i++) chk("trunc_order", pkt_log.size() > i ? pkt_log[i] : -1, i == 1 ? 0 : 1);

      // reset in the middle of a packet drops the grant at once
      add_pkt(0, 'h50, 5);
      run(3, 0, 1'b0);
      s_tvalid = 2'b11;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("midrst_m_tvalid", m_tvalid, 0);
      chk("midrst_s_tready", s_tready, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_trunc", trunc_flags, 0);
      rst = 1'b0;
      model_reset();
      add_pkt(0, 'h70, 1); add_pkt(1, 'h80, 1);
      drain(100, 0, 1'b0);
      run(2, 0, 1'b0);
      chk("midrst_first", pkt_log.size() > 0 ? pkt_log[0] : -1, 0);

`ifdef ARB_HEADER_EN
      do_reset();
      q[1].push_back('{8'h55, 1'b0});
      q[1].push_back('{8'h66, 1'b1});
      drain(100, 0, 1'b0);
      run(2, 0, 1'b0);
      chk("hdr_count", all_log.size(), 3);
      chk("hdr_beat0", all_log.size() > 0 ? 32'(all_log[0]) : 32'hDEAD, 32'h0A1);
      chk("hdr_beat1", all_log.size() > 1 ? 32'(all_log[1]) : 32'hDEAD, 32'h055);
      chk("hdr_beat2", all_log.size() > 2 ? 32'(all_log[2]) : 32'hDEAD, 32'h166);
`endif

      // randomized traffic with valid gaps and random backpressure
      do_reset();
      for (int p = 0; p < 30; p++)
         for (int i = 0; i < N; i++) add_pkt(i, int'($urandom_range(255)), int'($urandom_range(1, 7)));
      drain(6000, 2, 1'b1);
      run(3, 2, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end
endmodule

// File: doc/usb_stream_arbiter.md
Name: usb_stream_arbiter

Overview:
- Packet-aware round-robin arbiter that shares the single AXI-Stream sink of the ft232h USB FIFO bridge between NUM_SOURCES producers (ADC capture, status, debug).
- Sits on the sys_clk side, between the producers and the ft232h sys_axis sink.
- A grant is held for a whole packet, up to tlast, so packets from different sources never interleave on the USB link.

Parameters:
- NUM_SOURCES, 2, number of requesting streams (2..16)
- DATA_WIDTH, 8, tdata width in bits; matches the FTDI byte bus
- MAX_BEATS, 256, maximum beats per grant before forced packet termination (>=2)

Ports:
- clk  input  1  system clock (sys_clk domain)
- rst  input  1  synchronous, active-high reset
- s_tdata  input  NUM_SOURCES*DATA_WIDTH  source data; source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- s_tvalid  input  NUM_SOURCES  per-source valid
- s_tlast  input  NUM_SOURCES  per-source end of packet
- s_tready  output  NUM_SOURCES  per-source ready
- m_tdata  output  DATA_WIDTH  data to the ft232h sink
- m_tvalid  output  1  valid to the sink
- m_tlast  output  1  end of packet to the sink
- m_tready  input  1  ready from the sink
- grant_id  output  $clog2(NUM_SOURCES) (min 1)  currently or last granted source
- busy  output  1  high while a packet is in progress
- trunc_flags  output  NUM_SOURCES  sticky per source: a packet was cut at MAX_BEATS

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high.
- Reset values:
  - state=IDLE; m_tvalid=0; m_tlast=0; m_tdata=0
  - s_tready=0; busy=0; grant_id=0; trunc_flags=0; beat counter=0
  - last_grant=NUM_SOURCES-1, so source 0 wins first.
- Reset mid-packet: the grant is dropped immediately. No further beats are forwarded. The partial packet is not terminated; the host resynchronises.
- State IDLE:
  - m_tvalid=0, all s_tready=0.
  - If any s_tvalid is high, pick the first asserted source searching from last_grant+1 upward, wrapping modulo NUM_SOURCES.
  - Register the winner into grant_id and set busy=1.
  - Go to HEADER if ARB_HEADER_EN is defined, else STREAM.
  - Arbitration costs exactly one cycle: the first beat of the winner can be accepted no earlier than the cycle after the request is seen.
- State STREAM, combinational pass-through of the granted source:
  - m_tdata = s_tdata[grant]; m_tvalid = s_tvalid[grant]
  - s_tready[grant] = m_tready; all other s_tready = 0
  - m_tlast = s_tlast[grant] OR (beat counter == MAX_BEATS-1)
- Beat transfer (m_tvalid & m_tready): the beat counter increments.
- End of packet: when a beat transfers with m_tlast=1, set last_grant<=grant, clear the counter and busy, and return to IDLE.
- Truncation: if a beat transfers with the counter at MAX_BEATS-1 and s_tlast[grant]=0:
  - m_tlast is still asserted (forced).
  - trunc_flags[grant] is set and stays set until rst.
  - The grant is released. The remaining beats of that source are arbitrated later as a new packet.
- A source deasserting tvalid mid-packet keeps the grant. There is no timeout, and other sources wait.
- A new request arriving in the same cycle a packet ends is considered in the following IDLE cycle. The source that just finished has lowest priority.
- Data width: no width conversion; tdata is passed bit-exact.
- Handshake compliance: no combinational path from m_tready to m_tvalid.

Optional Feature:
- Macro: ARB_HEADER_EN
- Defined:
  - HEADER state is inserted after IDLE.
  - Header beat: m_tvalid=1, m_tlast=0, m_tdata = 8'hA0 | grant_id (low 4 bits); upper DATA_WIDTH-8 bits are zero.
  - All s_tready=0 during the header.
  - On m_tready go to STREAM.
  - The header does not count toward MAX_BEATS.
- Undefined:
  - HEADER state and logic are absent.
  - IDLE goes directly to STREAM, and the output is raw interleaved packets.

Test Plan:
- Single source 0 sends a 4-beat packet 0x10..0x13 with m_tready=1 -> m_tdata 0x10,0x11,0x12,0x13; m_tlast only on 0x13; grant_id=0; busy falls the cycle after 0x13.
- Sources 0 and 1 both hold valid 3-beat packets continuously -> output alternates source 0, 1, 0, 1 by whole packets; no interleaving within a packet.
- Backpressure: toggle m_tready 1/0 every cycle during a 5-beat packet -> all 5 bytes delivered in order, none duplicated; s_tready[g] mirrors m_tready.
- MAX_BEATS=4, source 1 sends 6 beats with tlast on beat 6 -> beat 4 output with m_tlast=1; trunc_flags=2'b10; beats 5-6 follow as a separate packet after source 0 is served if it is requesting.
- Assert rst mid-packet after beat 2 of 5 -> next cycle m_tvalid=0, s_tready=0, busy=0, trunc_flags=0; after release, source 0 is granted first.
- ARB_HEADER_EN defined, source 1 sends 2 beats 0x55,0x66 -> output 0xA1, 0x55, 0x66; m_tlast only on 0x66.
